// File: rtl/gemm_pipe_pkg.sv
// gemm_pipe_pkg: shared helpers for the GEMM elastic pipeline blocks.
//   occ_width(depth)       : width of an occupancy count for 0..depth words.
//   params_legal(dw, depth): parameter legality check used at elaboration.
package gemm_pipe_pkg;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_legal(input int data_width, input int depth);
        return (data_width >= 1) && (depth >= 1);
    endfunction

endpackage

// File: rtl/pipe_reg_if.sv
// pipe_reg_if: valid/ready handshake bundle of the elastic pipeline register.
//   in_valid/in_ready/in_data    : upstream side
//   out_valid/out_ready/out_data : downstream side
//   occupancy                    : number of valid stages
//   flush                        : synchronous discard (only with PIPE_REG_FLUSH_EN)
// Modports: master = the environment driving/consuming the pipe,
//           slave  = the pipe itself.
interface pipe_reg_if
    import gemm_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
);
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_WIDTH-1:0]       in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH-1:0]       out_data;
    logic [occ_width(DEPTH)-1:0] occupancy;
`ifdef PIPE_REG_FLUSH_EN
    logic                        flush;

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, occupancy
    );
    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, occupancy
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
`endif
endinterface

// File: rtl/pipe_stage.sv
// pipe_stage: one valid/data register pair of the elastic pipeline.
//   prev_valid/prev_data : word offered by the previous stage (or upstream)
//   next_ready           : ready of the following stage (or downstream)
//   flush                : clear valid at the next edge, data holds
//   valid/data           : registered stage contents
//   ready                : stage can take a word this cycle
module pipe_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  prev_valid,
    input  logic [DATA_WIDTH-1:0] prev_data,
    input  logic                  next_ready,
    input  logic                  flush,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  ready
);

    // An empty stage always accepts, which is what collapses bubbles.
    assign ready = ~valid | next_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (ready) begin
                valid <= prev_valid;
            end
            // Bubbles leave the data register untouched.
            if (!flush && ready && prev_valid) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: elastic pipeline register, DEPTH valid/ready stages of
// DATA_WIDTH bits with bubble collapsing and an occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipe_reg_if.slave (in_*, out_*, occupancy, optional flush)
// Optional feature macro: PIPE_REG_FLUSH_EN adds the synchronous flush input.
module pipe_reg
    import gemm_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input logic       clk,
    input logic       rst_n,
    pipe_reg_if.slave bus
);

    localparam int OCC_W = occ_width(DEPTH);

    if (!params_legal(DATA_WIDTH, DEPTH)) begin : g_param_check
        $error("pipe_reg: DATA_WIDTH and DEPTH must both be >= 1");
    end

    logic flush_i;
`ifdef PIPE_REG_FLUSH_EN
    assign flush_i = bus.flush;
`else
    assign flush_i = 1'b0;
`endif

    // rdy[i] is the ready of stage i; rdy[DEPTH] is the downstream ready.
    logic [DEPTH:0]        rdy;
    logic [DEPTH-1:0]      valid_q;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [OCC_W-1:0]      occ;

    assign rdy[DEPTH] = bus.out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic                  prev_valid;
        logic [DATA_WIDTH-1:0] prev_data;

        if (i == 0) begin : g_head
            assign prev_valid = bus.in_valid;
            assign prev_data  = bus.in_data;
        end else begin : g_body
            assign prev_valid = valid_q[i-1];
            assign prev_data  = data_q[i-1];
        end

        pipe_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .prev_valid (prev_valid),
            .prev_data  (prev_data),
            .next_ready (rdy[i+1]),
            .flush      (flush_i),
            .valid      (valid_q[i]),
            .data       (data_q[i]),
            .ready      (rdy[i])
        );
    end

    // Flush masks both handshakes so no word crosses either boundary.
    assign bus.in_ready  = rdy[0] & ~flush_i;
    assign bus.out_valid = valid_q[DEPTH-1] & ~flush_i;
    assign bus.out_data  = data_q[DEPTH-1];

    always_comb begin
        occ = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(valid_q[i]);
        end
    end

    assign bus.occupancy = occ;

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: self-checking bench for pipe_reg (DATA_WIDTH=32, DEPTH=3).
// The reference model keeps the in-flight words as an ordered list, each
// with its current stage position; a word moves forward whenever the slot
// in front of it is free after the word ahead has moved.
module tb_pipe_reg;
    import gemm_pipe_pkg::*;

    localparam int DW = 32;
    localparam int DP = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_reg_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    pipe_reg #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int              pos_q [$];
    logic [DW-1:0]   dat_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called shortly after a rising edge; drives one cycle of inputs,
    // checks outputs against the model, then advances through the edge.
    task automatic do_cycle(input logic v, input logic [DW-1:0] d, input logic ordy,
                            input logic fl, output bit acc);
        int np [$];
        int lim;
        bit leaves, exp_ir, exp_ov;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
`ifdef PIPE_REG_FLUSH_EN
        bus.flush     = fl;
`endif
        // Slot DP stands for "left the pipe"; reachable only with out_ready.
        lim = ordy ? DP + 1 : DP;
        foreach (pos_q[k]) begin
            np.push_back((pos_q[k] + 1 < lim) ? pos_q[k] + 1 : pos_q[k]);
            lim = np[k];
        end
        leaves = (np.size() > 0) && (np[0] == DP);
        exp_ir = !fl && ((np.size() == 0) || (np[np.size()-1] > 0));
        exp_ov = !fl && (pos_q.size() > 0) && (pos_q[0] == DP - 1);
        #1;
        check("in_ready", bus.in_ready, exp_ir);
        check("out_valid", bus.out_valid, exp_ov);
        if (exp_ov) check("out_data", bus.out_data, dat_q[0]);
        check("occupancy", bus.occupancy, pos_q.size());
        acc = v && exp_ir;
        @(posedge clk);
        if (fl) begin
            pos_q.delete();
            dat_q.delete();
        end else begin
            pos_q = np;
            if (leaves) begin
                void'(pos_q.pop_front());
                void'(dat_q.pop_front());
            end
            if (acc) begin
                pos_q.push_back(0);
                dat_q.push_back(d);
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        bit a;
        for (int i = 0; i < n; i++) do_cycle(1'b0, '0, ordy, 1'b0, a);
    endtask

    initial begin
        bit            a;
        logic [DW-1:0] pend;
        bit            have;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef PIPE_REG_FLUSH_EN
        bus.flush     = 1'b0;
`endif
        #2;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, '0);
        check("rst_occupancy", bus.occupancy, 0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back stream with downstream always ready.
        for (int i = 1; i <= 16; i++) begin
            do_cycle(1'b1, DW'(i), 1'b1, 1'b0, a);
            check("stream_accept", a, 1'b1);
        end
        idle(4, 1'b1);

        // Fill while stalled, then release.
        do_cycle(1'b1, 32'hA, 1'b0, 1'b0, a);
        do_cycle(1'b1, 32'hB, 1'b0, 1'b0, a);
        do_cycle(1'b1, 32'hC, 1'b0, 1'b0, a);
        do_cycle(1'b1, 32'hD, 1'b0, 1'b0, a);
        check("full_reject_d", a, 1'b0);
        do_cycle(1'b1, 32'hD, 1'b0, 1'b0, a);
        do_cycle(1'b1, 32'hD, 1'b1, 1'b0, a);
        check("full_swap_d", a, 1'b1);
        idle(5, 1'b1);

        // Bubble collapse under stall.
        do_cycle(1'b1, 32'h5, 1'b0, 1'b0, a);
        idle(2, 1'b0);
        do_cycle(1'b1, 32'h6, 1'b0, 1'b0, a);
        idle(2, 1'b0);
        check("bubble_occ", bus.occupancy, 2);
        check("bubble_head", bus.out_data, 32'h5);
        idle(4, 1'b1);

        // Full pipe with simultaneous in/out transfers.
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'h100 + DW'(i), 1'b0, 1'b0, a);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 32'h200 + DW'(i), 1'b1, 1'b0, a);
            check("full_xfer_occ", bus.occupancy, DP);
        end
        idle(4, 1'b1);

        // Randomised traffic, holding an offered word until accepted.
        have = 1'b0;
        pend = '0;
        for (int i = 0; i < 400; i++) begin
            logic v, r;
            if (!have) begin
                have = ($urandom_range(0, 3) != 0);
                pend = $urandom;
            end
            v = have;
            r = ($urandom_range(0, 2) != 0);
            do_cycle(v, pend, r, 1'b0, a);
            if (a) have = 1'b0;
        end
        idle(5, 1'b1);

        // Asynchronous reset between edges with a full pipe.
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'h31 + DW'(i), 1'b0, 1'b0, a);
        check("pre_reset_occ", bus.occupancy, 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", bus.out_valid, 1'b0);
        check("async_rst_out_data", bus.out_data, '0);
        check("async_rst_occupancy", bus.occupancy, 0);
        check("async_rst_in_ready", bus.in_ready, 1'b1);
        pos_q.delete();
        dat_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_cycle(1'b1, 32'h77, 1'b1, 1'b0, a);
        check("post_reset_accept", a, 1'b1);
        idle(4, 1'b1);

`ifdef PIPE_REG_FLUSH_EN
        // Flush of a full pipe while a word is offered.
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'h51 + DW'(i), 1'b0, 1'b0, a);
        do_cycle(1'b1, 32'h99, 1'b1, 1'b1, a);
        check("flush_accept", a, 1'b0);
        check("flush_occ", bus.occupancy, 0);
        idle(4, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
